// File: rtl/ed25519_pkg.sv
// Shared Ed25519 constants, identity point and the scalar-multiply state encoding.
package ed25519_pkg;

    localparam int ED_W     = 256;
    localparam int ED_QBITS = 255;

    // Field prime q = 2^255 - 19 and group order l = 2^252 + 27742317777372353535851937790883648493.
    localparam logic [255:0] ED_Q  = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [255:0] ED_L  = 256'h10000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;
    localparam logic [255:0] ED_D2 = 256'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159;

    localparam logic [255:0] ED_ID_X = 256'd0;
    localparam logic [255:0] ED_ID_Y = 256'd1;
    localparam logic [255:0] ED_ID_Z = 256'd1;
    localparam logic [255:0] ED_ID_T = 256'd0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DBL_ISSUE = 3'd1,
        S_DBL_WAIT  = 3'd2,
        S_ADD_ISSUE = 3'd3,
        S_ADD_WAIT  = 3'd4,
        S_FINISH    = 3'd5
    } sm_state_e;

endpackage

// File: rtl/point_add.sv
// Unified extended-coordinate Edwards point addition (valid for doubling too), one
// shared radix-2^32 interleaved modular multiplier sequenced over nine products.
module point_add
    import ed25519_pkg::*;
#(
    parameter int W = ED_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    input  logic [W-1:0] t1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] z2,
    input  logic [W-1:0] t2,
    output logic         done,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic [W-1:0] z3,
    output logic [W-1:0] t3
);

    localparam int DIG  = 32;
    localparam int NDIG = W / DIG;
    localparam int DW   = $clog2(NDIG);
    localparam int SW   = W + DIG;
    localparam logic [W:0] Q1 = (W+1)'(ED_Q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q1) s = s - Q1;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = a - b;
        if (a < b) r = r + Q1[W-1:0];
        return r;
    endfunction

    // 2^255 == 19 (mod q): fold the bits above 255 back in, then one conditional subtract.
    function automatic logic [W-1:0] fold(input logic [SW-1:0] s);
        logic [W:0] r;
        r = (W+1)'(s[ED_QBITS-1:0]) + (W+1)'(s[SW-1:ED_QBITS]) * (W+1)'(19);
        if (r >= Q1) r = r - Q1;
        return r[W-1:0];
    endfunction

    // Result slots: 0 A, 1 B, 2 C, 3 D/2, 4 X3, 5 Y3, 6 Z3, 7 T3.
    function automatic logic [2:0] wb_idx(input logic [3:0] step);
        case (step)
            4'd0:    return 3'd0;
            4'd1:    return 3'd1;
            4'd2:    return 3'd2;
            4'd3:    return 3'd2;
            4'd4:    return 3'd3;
            4'd5:    return 3'd4;
            4'd6:    return 3'd5;
            4'd7:    return 3'd7;
            default: return 3'd6;
        endcase
    endfunction

    logic [W-1:0]  op_q [8];
    logic [W-1:0]  op_d [8];
    logic [W-1:0]  res_q [8];
    logic [W-1:0]  res_d [8];
    logic [W-1:0]  acc_q, acc_d;
    logic [3:0]    step_q, step_d;
    logic [DW-1:0] dig_q, dig_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]   e, f, g, h, d2, ma, mb, prod;
    logic [DIG-1:0] digit;

    always_comb begin
        op_d   = op_q;
        res_d  = res_q;
        acc_d  = acc_q;
        step_d = step_q;
        dig_d  = dig_q;
        busy_d = busy_q;
        done_d = 1'b0;

        d2 = add_mod(res_q[3], res_q[3]);
        e  = sub_mod(res_q[1], res_q[0]);
        h  = add_mod(res_q[1], res_q[0]);
        f  = sub_mod(d2, res_q[2]);
        g  = add_mod(d2, res_q[2]);

        case (step_q)
            4'd0:    begin ma = sub_mod(op_q[1], op_q[0]); mb = sub_mod(op_q[5], op_q[4]); end
            4'd1:    begin ma = add_mod(op_q[1], op_q[0]); mb = add_mod(op_q[5], op_q[4]); end
            4'd2:    begin ma = op_q[3];  mb = op_q[7];       end
            4'd3:    begin ma = res_q[2]; mb = W'(ED_D2);     end
            4'd4:    begin ma = op_q[2];  mb = op_q[6];       end
            4'd5:    begin ma = e;        mb = f;             end
            4'd6:    begin ma = g;        mb = h;             end
            4'd7:    begin ma = e;        mb = h;             end
            4'd8:    begin ma = f;        mb = g;             end
            default: begin ma = '0;       mb = '0;            end
        endcase

        digit = mb[int'(dig_q)*DIG +: DIG];
        prod  = fold((SW'(acc_q) << DIG) + SW'(ma) * SW'(digit));

        if (!busy_q) begin
            if (start) begin
                op_d   = '{x1, y1, z1, t1, x2, y2, z2, t2};
                busy_d = 1'b1;
                step_d = 4'd0;
                dig_d  = DW'(NDIG - 1);
                acc_d  = '0;
            end
        end else if (dig_q == '0) begin
            res_d[wb_idx(step_q)] = prod;
            acc_d = '0;
            dig_d = DW'(NDIG - 1);
            if (step_q == 4'd8) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                step_d = step_q + 4'd1;
            end
        end else begin
            acc_d = prod;
            dig_d = dig_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                op_q[i]  <= '0;
                res_q[i] <= '0;
            end
            acc_q  <= '0;
            step_q <= '0;
            dig_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            res_q  <= res_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            dig_q  <= dig_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign x3   = res_q[4];
    assign y3   = res_q[5];
    assign z3   = res_q[6];
    assign t3   = res_q[7];

endmodule

// File: rtl/ed25519_scalar_mult.sv
// MSB-first double-and-add scalar multiplication controller around a single point_add.
// Handshake: start is taken only in IDLE; pa_start is a one-cycle request and the next is issued only after pa_done.
module ed25519_scalar_mult
    import ed25519_pkg::*;
#(
    parameter int NBITS      = 256,
    parameter int W          = ED_W,
    parameter int CONST_TIME = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] n,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [W-1:0]     z,
    input  logic [W-1:0]     t,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     x3,
    output logic [W-1:0]     y3,
    output logic [W-1:0]     z3,
    output logic [W-1:0]     t3,
    output logic [15:0]      pa_ops,
    output sm_state_e        dbg_state
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    sm_state_e        state_q, state_d, adv_state;
    logic [NBITS-1:0] n_q, n_d;
    logic [W-1:0]     bx_q, by_q, bz_q, bt_q, bx_d, by_d, bz_d, bt_d;
    logic [W-1:0]     ax_q, ay_q, az_q, at_q, ax_d, ay_d, az_d, at_d;
    logic [W-1:0]     rx_q, ry_q, rz_q, rt_q, rx_d, ry_d, rz_d, rt_d;
    logic [IW-1:0]    idx_q, idx_d, adv_idx;
    logic [15:0]      ops_q, ops_d;
    logic             bit_set, use_base;

    logic             pa_start, pa_done;
    logic [W-1:0]     pa_x2, pa_y2, pa_z2, pa_t2;
    logic [W-1:0]     pa_rx, pa_ry, pa_rz, pa_rt;

    assign bit_set = n_q[idx_q];

    always_comb begin
        state_d = state_q;
        n_d  = n_q;
        bx_d = bx_q; by_d = by_q; bz_d = bz_q; bt_d = bt_q;
        ax_d = ax_q; ay_d = ay_q; az_d = az_q; at_d = at_q;
        rx_d = rx_q; ry_d = ry_q; rz_d = rz_q; rt_d = rt_q;
        idx_d    = idx_q;
        ops_d    = ops_q;
        pa_start = 1'b0;
        use_base = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE) && (state_q != S_FINISH);

        adv_state = (idx_q == '0) ? S_FINISH : S_DBL_ISSUE;
        adv_idx   = (idx_q == '0) ? idx_q : idx_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d  = n;
                    bx_d = x; by_d = y; bz_d = z; bt_d = t;
                    ax_d = W'(ED_ID_X); ay_d = W'(ED_ID_Y);
                    az_d = W'(ED_ID_Z); at_d = W'(ED_ID_T);
                    idx_d   = IW'(NBITS - 1);
                    ops_d   = '0;
                    state_d = S_DBL_ISSUE;
                end
            end
            S_DBL_ISSUE: begin
                pa_start = 1'b1;
                ops_d    = ops_q + 16'd1;
                state_d  = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (pa_done) begin
                    ax_d = pa_rx; ay_d = pa_ry; az_d = pa_rz; at_d = pa_rt;
                    if (bit_set || CONST_TIME == 1) begin
                        state_d = S_ADD_ISSUE;
                    end else begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                end
            end
            S_ADD_ISSUE: begin
                pa_start = 1'b1;
                use_base = 1'b1;
                ops_d    = ops_q + 16'd1;
                state_d  = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (pa_done) begin
                    // Constant-time dummy adds still take the full point_add time but are dropped here.
                    if (bit_set) begin
                        ax_d = pa_rx; ay_d = pa_ry; az_d = pa_rz; at_d = pa_rt;
                    end
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Results load on entry to FINISH so they are already valid while done is high.
        if (state_d == S_FINISH) begin
            if (n_q == '0) begin
                rx_d = W'(ED_ID_X); ry_d = W'(ED_ID_Y); rz_d = W'(ED_ID_Z); rt_d = W'(ED_ID_T);
            end else begin
                rx_d = ax_d; ry_d = ay_d; rz_d = az_d; rt_d = at_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q  <= '0;
            bx_q <= '0; by_q <= '0; bz_q <= '0; bt_q <= '0;
            ax_q <= '0; ay_q <= '0; az_q <= '0; at_q <= '0;
            rx_q <= '0; ry_q <= '0; rz_q <= '0; rt_q <= '0;
            idx_q <= '0;
            ops_q <= '0;
        end else begin
            state_q <= state_d;
            n_q  <= n_d;
            bx_q <= bx_d; by_q <= by_d; bz_q <= bz_d; bt_q <= bt_d;
            ax_q <= ax_d; ay_q <= ay_d; az_q <= az_d; at_q <= at_d;
            rx_q <= rx_d; ry_q <= ry_d; rz_q <= rz_d; rt_q <= rt_d;
            idx_q <= idx_d;
            ops_q <= ops_d;
        end
    end

    assign pa_x2 = use_base ? bx_q : ax_q;
    assign pa_y2 = use_base ? by_q : ay_q;
    assign pa_z2 = use_base ? bz_q : az_q;
    assign pa_t2 = use_base ? bt_q : at_q;

    point_add #(
        .W (W)
    ) u_point_add (
        .clk   (clk),
        .rst   (rst),
        .start (pa_start),
        .x1    (ax_q),
        .y1    (ay_q),
        .z1    (az_q),
        .t1    (at_q),
        .x2    (pa_x2),
        .y2    (pa_y2),
        .z2    (pa_z2),
        .t2    (pa_t2),
        .done  (pa_done),
        .x3    (pa_rx),
        .y3    (pa_ry),
        .z3    (pa_rz),
        .t3    (pa_rt)
    );

    assign x3        = rx_q;
    assign y3        = ry_q;
    assign z3        = rz_q;
    assign t3        = rt_q;
    assign pa_ops    = ops_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ed25519_scalar_mult.sv
// Directed bench: three configurations checked against an affine-coordinate golden model.
module tb_ed25519_scalar_mult;
    import ed25519_pkg::*;

    localparam logic [255:0] BX = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    localparam logic [255:0] BY = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   start_v, busy_v, done_v;
    logic [3:0]   n0, n1;
    logic [255:0] n2;
    logic [255:0] xi, yi, zi, ti;
    logic [255:0] x3_v [3];
    logic [255:0] y3_v [3];
    logic [255:0] z3_v [3];
    logic [255:0] t3_v [3];
    logic [15:0]  ops_v [3];
    sm_state_e    st_v [3];

    ed25519_scalar_mult #(.NBITS(4), .W(256), .CONST_TIME(0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .n(n0), .x(xi), .y(yi), .z(zi), .t(ti),
        .busy(busy_v[0]), .done(done_v[0]), .x3(x3_v[0]), .y3(y3_v[0]), .z3(z3_v[0]), .t3(t3_v[0]),
        .pa_ops(ops_v[0]), .dbg_state(st_v[0]));

    ed25519_scalar_mult #(.NBITS(4), .W(256), .CONST_TIME(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .n(n1), .x(xi), .y(yi), .z(zi), .t(ti),
        .busy(busy_v[1]), .done(done_v[1]), .x3(x3_v[1]), .y3(y3_v[1]), .z3(z3_v[1]), .t3(t3_v[1]),
        .pa_ops(ops_v[1]), .dbg_state(st_v[1]));

    ed25519_scalar_mult #(.NBITS(256), .W(256), .CONST_TIME(0)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .n(n2), .x(xi), .y(yi), .z(zi), .t(ti),
        .busy(busy_v[2]), .done(done_v[2]), .x3(x3_v[2]), .y3(y3_v[2]), .z3(z3_v[2]), .t3(t3_v[2]),
        .pa_ops(ops_v[2]), .dbg_state(st_v[2]));

    int checks   = 0;
    int failures = 0;
    int done_cnt [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) done_cnt[k]++;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- golden model: affine arithmetic mod q ----------------
    logic [255:0] d_c;

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'd0, a} * {256'd0, b};
        p = p % {256'd0, ED_Q};
        return p[255:0];
    endfunction

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, ED_Q}) s = s - {1'b0, ED_Q};
        return s[255:0];
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        return addm(a, ED_Q - b);
    endfunction

    function automatic logic [255:0] invm(input logic [255:0] a);
        logic [255:0] r, e;
        r = 256'd1;
        e = ED_Q - 256'd2;
        for (int i = 255; i >= 0; i--) begin
            r = mulm(r, r);
            if (e[i]) r = mulm(r, a);
        end
        return r;
    endfunction

    function automatic void aff_add(input logic [255:0] x1, input logic [255:0] y1,
                                    input logic [255:0] x2, input logic [255:0] y2,
                                    output logic [255:0] xr, output logic [255:0] yr);
        logic [255:0] k;
        k  = mulm(d_c, mulm(mulm(x1, x2), mulm(y1, y2)));
        xr = mulm(addm(mulm(x1, y2), mulm(y1, x2)), invm(addm(256'd1, k)));
        yr = mulm(addm(mulm(y1, y2), mulm(x1, x2)), invm(subm(256'd1, k)));
    endfunction

    function automatic void aff_mul(input logic [3:0] k, output logic [255:0] rx, output logic [255:0] ry);
        logic [255:0] ax, ay, tx, ty;
        ax = 256'd0;
        ay = 256'd1;
        for (int i = 3; i >= 0; i--) begin
            aff_add(ax, ay, ax, ay, tx, ty);
            ax = tx; ay = ty;
            if (k[i]) begin
                aff_add(ax, ay, BX, BY, tx, ty);
                ax = tx; ay = ty;
            end
        end
        rx = ax;
        ry = ay;
    endfunction

    task automatic check_aff(input string tag, input int sel, input logic [255:0] ex, input logic [255:0] ey);
        logic [255:0] zinv;
        zinv = invm(z3_v[sel]);
        check_eq({tag, "_x"}, mulm(x3_v[sel], zinv), ex);
        check_eq({tag, "_y"}, mulm(y3_v[sel], zinv), ey);
    endtask

    // ---------------- driver ----------------
    task automatic run(input string tag, input int sel, input logic [255:0] nv, input int budget,
                       input bit disturb, output int cycles);
        int  base_cnt;
        bit  seen;
        @(negedge clk);
        base_cnt = done_cnt[sel];
        case (sel)
            0:       n0 = nv[3:0];
            1:       n1 = nv[3:0];
            default: n2 = nv;
        endcase
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check_eq({tag, "_busy"}, 256'(busy_v[sel]), 256'd1);
        cycles = 1;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            if (disturb && cycles == 10) begin
                start_v[sel] = 1'b1;
                n0 = 4'b0001;
                xi = 256'h1234;
            end
            if (disturb && cycles == 11) start_v[sel] = 1'b0;
            @(negedge clk);
            cycles++;
            if (done_v[sel]) seen = 1'b1;
        end
        check_eq({tag, "_done"}, 256'(seen), 256'd1);
        check_eq({tag, "_busy_at_done"}, 256'(busy_v[sel]), 256'd0);
        xi = BX;
        repeat (3) @(negedge clk);
        #1;
        check_eq({tag, "_pulses"}, 256'(done_cnt[sel] - base_cnt), 256'd1);
    endtask

    logic [255:0] g1x, g1y, g2x, g2y, g11x, g11y;
    int cyc_a, cyc_b, cyc_tmp, base_cnt, waited;
    bit found;

    initial begin
        rst     = 1'b1;
        start_v = 3'b000;
        n0 = 4'd0; n1 = 4'd0; n2 = 256'd0;
        xi = BX;
        yi = BY;
        zi = 256'd1;
        ti = mulm(BX, BY);
        d_c = subm(256'd0, mulm(256'd121665, invm(256'd121666)));
        aff_mul(4'd1, g1x, g1y);
        aff_mul(4'd2, g2x, g2y);
        aff_mul(4'd11, g11x, g11y);

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 256'(busy_v), 256'd0);
        check_eq("rst_done", 256'(done_v), 256'd0);
        check_eq("rst_ops0", 256'(ops_v[0]), 256'd0);
        check_eq("rst_ops2", 256'(ops_v[2]), 256'd0);
        check_eq("rst_x3", x3_v[0], 256'd0);
        check_eq("rst_y3", y3_v[0], 256'd0);
        check_eq("rst_z3", z3_v[1], 256'd0);
        rst = 1'b0;

        // zero scalar: four doubles only, canonical identity result
        run("n0", 0, 256'd0, 2000, 1'b0, cyc_tmp);
        check_eq("n0_ops", 256'(ops_v[0]), 256'd4);
        check_eq("n0_x3", x3_v[0], 256'd0);
        check_eq("n0_y3", y3_v[0], 256'd1);
        check_eq("n0_z3", z3_v[0], 256'd1);
        check_eq("n0_t3", t3_v[0], 256'd0);

        run("n11", 0, 256'd11, 2000, 1'b0, cyc_tmp);
        check_eq("n11_ops", 256'(ops_v[0]), 256'd7);
        check_aff("n11", 0, g11x, g11y);

        // constant time: same op count and latency regardless of n
        run("ct11", 1, 256'd11, 2000, 1'b0, cyc_a);
        check_eq("ct11_ops", 256'(ops_v[1]), 256'd8);
        check_aff("ct11", 1, g11x, g11y);
        run("ct1", 1, 256'd1, 2000, 1'b0, cyc_b);
        check_eq("ct1_ops", 256'(ops_v[1]), 256'd8);
        check_aff("ct1", 1, g1x, g1y);
        check_eq("ct_cycles", 256'(cyc_a), 256'(cyc_b));

        // start re-pulsed and inputs changed while busy
        run("dist", 0, 256'd11, 2000, 1'b1, cyc_tmp);
        check_eq("dist_ops", 256'(ops_v[0]), 256'd7);
        check_aff("dist", 0, g11x, g11y);

        // abort during ADD_WAIT, then a fresh run
        @(negedge clk);
        n0 = 4'b1011;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (st_v[0] == S_ADD_WAIT) found = 1'b1;
        end
        check_eq("abort_reach_add_wait", 256'(found), 256'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_state", 256'(st_v[0]), 256'(S_IDLE));
        check_eq("abort_busy", 256'(busy_v[0]), 256'd0);
        check_eq("abort_ops", 256'(ops_v[0]), 256'd0);
        check_eq("abort_x3", x3_v[0], 256'd0);
        check_eq("abort_y3", y3_v[0], 256'd0);
        base_cnt = done_cnt[0];
        repeat (200) @(negedge clk);
        #1;
        check_eq("abort_no_late_done", 256'(done_cnt[0] - base_cnt), 256'd0);
        check_eq("abort_still_idle", 256'(st_v[0]), 256'(S_IDLE));
        run("n2", 0, 256'd2, 2000, 1'b0, cyc_tmp);
        check_eq("n2_ops", 256'(ops_v[0]), 256'd5);
        check_aff("n2", 0, g2x, g2y);

        // full width: (l-1)*B = -B
        run("lm1", 2, ED_L - 256'd1, 60000, 1'b0, cyc_tmp);
        check_eq("lm1_ops", 256'(ops_v[2]), 256'(256 + $countones(ED_L - 256'd1)));
        check_aff("lm1", 2, ED_Q - BX, BY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
